// File: rtl/wb_stage_pkg.sv
// Shared CPU constants for the write-back stage: load-type and write-back-source
// encodings, the latched WB payload layout, and the link-address helper.
package wb_stage_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_ALU2 = 2'b11;

  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  sel_wbdata;
    logic [3:0]  reg_we;
    logic [4:0]  dest;
    logic [31:0] aluout;
    logic [2:0]  ld_op;
    logic [1:0]  addr_low;
  } ws_payload_t;

  // Return address skips the branch delay slot; the add wraps modulo 2^32.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + LINK_OFFSET;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: selects the addressed byte/halfword from
// the SRAM word and sign- or zero-extends it according to the load type.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_low_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // A misaligned halfword ignores addr_low[0]; the alignment fault is raised upstream.
    half_sel = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (ld_op_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'd0, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: latches the MEM-stage result, produces register
// file write controls/data, forwarding info, debug PC and a retire counter.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_sel_wbdata,
  input  logic [3:0]  ms_reg_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_aluout,
  input  logic [2:0]  ms_ld_op,
  input  logic [1:0]  ms_addr_low,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] debug_wb_pc,
  output logic [31:0] retire_cnt
);

  // Handshake: an instruction transfers MEM->WB on every rising edge where
  // ms_to_ws_valid=1 && ws_allowin=1; WB never stalls, so ws_allowin is tied to 1
  // and ms_to_ws_valid alone qualifies the transfer. flush overrides the transfer.
  logic        ws_valid_q, ws_valid_d;
  ws_payload_t ws_q, ws_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] load_data;
  logic        wr_en;

  assign ws_allowin = 1'b1;

  always_comb begin
    ws_valid_d = ms_to_ws_valid && !flush;
    ws_d       = ws_q;
    if (ms_to_ws_valid) begin
      ws_d.pc         = ms_pc;
      ws_d.sel_wbdata = ms_sel_wbdata;
      ws_d.reg_we     = ms_reg_we;
      ws_d.dest       = ms_dest;
      ws_d.aluout     = ms_aluout;
      ws_d.ld_op      = ms_ld_op;
      ws_d.addr_low   = ms_addr_low;
    end
    retire_cnt_d = retire_cnt_q;
    if (ws_valid_q && !flush) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q   <= 1'b0;
      ws_q         <= '0;
      retire_cnt_q <= 32'd0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      ws_q         <= ws_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  load_align u_load_align (
    .ld_op_i    (ws_q.ld_op),
    .addr_low_i (ws_q.addr_low),
    .rdata_i    (data_sram_rdata),
    .data_o     (load_data)
  );

  // $zero is never written, but the instruction still retires.
  assign wr_en = ws_valid_q && !flush && (ws_q.dest != 5'd0);

  always_comb begin
    rf_wdata = ws_q.aluout;
    case (ws_q.sel_wbdata)
      WB_SEL_ALU, WB_SEL_ALU2: rf_wdata = ws_q.aluout;
      WB_SEL_LOAD:             rf_wdata = load_data;
      WB_SEL_LINK:             rf_wdata = link_addr(ws_q.pc);
      default:                 rf_wdata = ws_q.aluout;
    endcase
  end

  assign rf_we        = wr_en ? ws_q.reg_we : 4'b0000;
  assign rf_waddr     = ws_q.dest;
  assign ws_fwd_valid = (rf_we != 4'b0000);
  assign ws_fwd_dest  = ws_q.dest;
  assign debug_wb_pc  = ws_q.pc;
  assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: load extension, link, ALU path,
// flush, $zero writes, back-to-back retirement, counter wrap and async reset.
module tb_wb_stage;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [1:0]  ms_sel_wbdata;
  logic [3:0]  ms_reg_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_aluout;
  logic [2:0]  ms_ld_op;
  logic [1:0]  ms_addr_low;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] debug_wb_pc;
  logic [31:0] retire_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;
  bit          pend     = 1'b0;

  wb_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ws_allowin      (ws_allowin),
    .ms_pc           (ms_pc),
    .ms_sel_wbdata   (ms_sel_wbdata),
    .ms_reg_we       (ms_reg_we),
    .ms_dest         (ms_dest),
    .ms_aluout       (ms_aluout),
    .ms_ld_op        (ms_ld_op),
    .ms_addr_low     (ms_addr_low),
    .data_sram_rdata (data_sram_rdata),
    .flush           (flush),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .ws_fwd_valid    (ws_fwd_valid),
    .ws_fwd_dest     (ws_fwd_dest),
    .debug_wb_pc     (debug_wb_pc),
    .retire_cnt      (retire_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One rising edge; the retire model counts an instruction held in WB unless flushed.
  task automatic tick();
    bit r;
    bit nv;
    r  = pend && !flush;
    nv = ms_to_ws_valid && !flush;
    @(posedge clk);
    if (r) exp_cnt = exp_cnt + 32'd1;
    pend = nv;
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [1:0] sel, input logic [3:0] we,
                       input logic [4:0] dest, input logic [31:0] alu, input logic [2:0] ldop,
                       input logic [1:0] addr);
    @(negedge clk);
    ms_pc          = pc;
    ms_sel_wbdata  = sel;
    ms_reg_we      = we;
    ms_dest        = dest;
    ms_aluout      = alu;
    ms_ld_op       = ldop;
    ms_addr_low    = addr;
    ms_to_ws_valid = 1'b1;
    tick();
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; ms_to_ws_valid = 1'b0; flush = 1'b0;
    ms_pc = '0; ms_sel_wbdata = '0; ms_reg_we = '0; ms_dest = '0;
    ms_aluout = '0; ms_ld_op = '0; ms_addr_low = '0; data_sram_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (ws_allowin !== 1'b1) $display("FAIL rst_allowin: got %b want 1", ws_allowin); else n_pass++;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL rst_rf_we: got %b want 0000", rf_we); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL rst_fwd_valid: got %b want 0", ws_fwd_valid); else n_pass++;
    n_checks++; if (debug_wb_pc !== 32'h0) $display("FAIL rst_debug_pc: got %h want 0", debug_wb_pc); else n_pass++;
    n_checks++; if (retire_cnt !== 32'h0) $display("FAIL rst_retire: got %h want 0", retire_cnt); else n_pass++;
    n_checks++; if (rf_waddr !== 5'd0) $display("FAIL rst_waddr: got %0d want 0", rf_waddr); else n_pass++;
    resetn = 1'b1;
    exp_cnt = 32'd0; pend = 1'b0;
  endtask

  task automatic test_lb();
    issue(32'h0000_0100, 2'b01, 4'hF, 5'd5, 32'h0, LD_LB, 2'd2);
    data_sram_rdata = 32'h12F4_5678;
    #1;
    n_checks++; if (rf_wdata !== 32'hFFFF_FFF4) $display("FAIL lb_wdata: got %h want fffffff4", rf_wdata); else n_pass++;
    n_checks++; if (rf_we !== 4'b1111) $display("FAIL lb_rf_we: got %b want 1111", rf_we); else n_pass++;
    n_checks++; if (rf_waddr !== 5'd5) $display("FAIL lb_waddr: got %0d want 5", rf_waddr); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b1) $display("FAIL lb_fwd_valid: got %b want 1", ws_fwd_valid); else n_pass++;
    n_checks++; if (ws_fwd_dest !== 5'd5) $display("FAIL lb_fwd_dest: got %0d want 5", ws_fwd_dest); else n_pass++;
    n_checks++; if (debug_wb_pc !== 32'h0000_0100) $display("FAIL lb_debug_pc: got %h want 00000100", debug_wb_pc); else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  op_t  [10] = '{LD_LHU, LD_LH, LD_LH, LD_LBU, LD_LB, LD_LB, LD_LW, LD_LHU, LD_LHU, 3'b111};
    logic [1:0]  adr_t [10] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1, 2'd0};
    logic [31:0] rd_t  [10] = '{32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD, 32'h12F45678, 32'h12F45680,
                                32'h7F000000, 32'hDEADBEEF, 32'h8001ABCD, 32'h8001ABCD, 32'hCAFEF00D};
    logic [31:0] exp_t [10] = '{32'h00008001, 32'hFFFF8001, 32'hFFFFABCD, 32'h00000056, 32'hFFFFFF80,
                                32'h0000007F, 32'hDEADBEEF, 32'h00008001, 32'h0000ABCD, 32'hCAFEF00D};
    for (int i = 0; i < 10; i++) begin
      issue(32'h0000_1000 + 32'(i * 4), 2'b01, 4'hF, 5'd8, 32'h5555_5555, op_t[i], adr_t[i]);
      data_sram_rdata = rd_t[i];
      #1;
      n_checks++;
      if (rf_wdata !== exp_t[i])
        $display("FAIL load_ext[%0d] op=%b addr=%0d: got %h want %h", i, op_t[i], adr_t[i], rf_wdata, exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_link();
    issue(32'hBFC0_0100, 2'b10, 4'hF, 5'd31, 32'h1234_5678, LD_LW, 2'd0);
    #1;
    n_checks++; if (rf_wdata !== 32'hBFC0_0108) $display("FAIL link_wdata: got %h want bfc00108", rf_wdata); else n_pass++;
    n_checks++; if (rf_waddr !== 5'd31) $display("FAIL link_waddr: got %0d want 31", rf_waddr); else n_pass++;
    issue(32'hFFFF_FFFC, 2'b10, 4'hF, 5'd31, 32'h0, LD_LW, 2'd0);
    #1;
    n_checks++; if (rf_wdata !== 32'h0000_0004) $display("FAIL link_wrap: got %h want 00000004", rf_wdata); else n_pass++;
  endtask

  task automatic test_alu();
    issue(32'h0000_2000, 2'b00, 4'b0011, 5'd12, 32'hA5A5_0001, LD_LB, 2'd1);
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (rf_wdata !== 32'hA5A5_0001) $display("FAIL alu00_wdata: got %h want a5a50001", rf_wdata); else n_pass++;
    n_checks++; if (rf_we !== 4'b0011) $display("FAIL alu_partial_we: got %b want 0011", rf_we); else n_pass++;
    issue(32'h0000_2004, 2'b11, 4'hF, 5'd13, 32'h0BAD_F00D, LD_LW, 2'd0);
    #1;
    n_checks++; if (rf_wdata !== 32'h0BAD_F00D) $display("FAIL alu11_wdata: got %h want 0badf00d", rf_wdata); else n_pass++;
  endtask

  task automatic test_flush_accept();
    logic [31:0] saved;
    idle();
    idle();
    saved = exp_cnt;
    n_checks++; if (retire_cnt !== saved) $display("FAIL flacc_pre_cnt: got %h want %h", retire_cnt, saved); else n_pass++;
    @(negedge clk);
    ms_pc = 32'h0000_3000; ms_sel_wbdata = 2'b00; ms_reg_we = 4'hF; ms_dest = 5'd7;
    ms_aluout = 32'h7777_7777; ms_to_ws_valid = 1'b1; flush = 1'b1;
    #1;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL flacc_we_now: got %b want 0000", rf_we); else n_pass++;
    tick();
    ms_to_ws_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL flacc_we_next: got %b want 0000", rf_we); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL flacc_fwd_next: got %b want 0", ws_fwd_valid); else n_pass++;
    idle();
    n_checks++; if (retire_cnt !== saved) $display("FAIL flacc_cnt: got %h want %h", retire_cnt, saved); else n_pass++;
  endtask

  task automatic test_flush_held();
    logic [31:0] saved;
    issue(32'h0000_3100, 2'b00, 4'hF, 5'd9, 32'h9999_9999, LD_LW, 2'd0);
    saved = exp_cnt;
    flush = 1'b1;
    #1;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL flheld_we: got %b want 0000", rf_we); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL flheld_fwd: got %b want 0", ws_fwd_valid); else n_pass++;
    @(negedge clk);
    tick();
    flush = 1'b0;
    #1;
    n_checks++; if (retire_cnt !== saved) $display("FAIL flheld_cnt: got %h want %h", retire_cnt, saved); else n_pass++;
  endtask

  task automatic test_dest0();
    logic [31:0] saved;
    issue(32'h0000_4000, 2'b00, 4'hF, 5'd0, 32'h1111_1111, LD_LW, 2'd0);
    saved = retire_cnt;
    #1;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL dest0_we: got %b want 0000", rf_we); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL dest0_fwd: got %b want 0", ws_fwd_valid); else n_pass++;
    idle();
    n_checks++; if (retire_cnt !== saved + 32'd1) $display("FAIL dest0_cnt: got %h want %h", retire_cnt, saved + 32'd1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] saved;
    idle();
    saved = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ms_pc = 32'h0000_0200 + 32'(i * 4); ms_sel_wbdata = 2'b00; ms_reg_we = 4'hF;
      ms_dest = 5'(i + 1); ms_aluout = 32'(i * 32'h11); ms_to_ws_valid = 1'b1;
      tick();
      #1;
      n_checks++; if (rf_waddr !== 5'(i + 1)) $display("FAIL b2b_waddr[%0d]: got %0d want %0d", i, rf_waddr, i + 1); else n_pass++;
      n_checks++; if (rf_wdata !== 32'(i * 32'h11)) $display("FAIL b2b_wdata[%0d]: got %h want %h", i, rf_wdata, 32'(i * 32'h11)); else n_pass++;
      n_checks++; if (retire_cnt !== saved + 32'(i)) $display("FAIL b2b_cnt[%0d]: got %h want %h", i, retire_cnt, saved + 32'(i)); else n_pass++;
    end
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    ms_pc = 32'($urandom_range(32'h7FFF_0000, 32'h7FFF_FFFF)); ms_dest = 5'd30;
    tick();
    #1;
    n_checks++; if (retire_cnt !== saved + 32'd3) $display("FAIL b2b_cnt_end: got %h want %h", retire_cnt, saved + 32'd3); else n_pass++;
    n_checks++; if (debug_wb_pc !== 32'h0000_0208) $display("FAIL hold_debug_pc: got %h want 00000208", debug_wb_pc); else n_pass++;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL hold_we: got %b want 0000", rf_we); else n_pass++;
  endtask

  task automatic test_wrap_and_async_reset();
    idle();
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff", retire_cnt); else n_pass++;
    issue(32'h0000_0300, 2'b00, 4'hF, 5'd3, 32'h3333_3333, LD_LW, 2'd0);
    idle();
    n_checks++; if (retire_cnt !== 32'h0) $display("FAIL wrap_cnt: got %h want 00000000", retire_cnt); else n_pass++;
    issue(32'h0000_0400, 2'b00, 4'hF, 5'd4, 32'h4444_4444, LD_LW, 2'd0);
    #1;
    n_checks++; if (rf_we !== 4'b1111) $display("FAIL arst_pre_we: got %b want 1111", rf_we); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (rf_we !== 4'b0000) $display("FAIL arst_we: got %b want 0000", rf_we); else n_pass++;
    n_checks++; if (ws_fwd_valid !== 1'b0) $display("FAIL arst_fwd: got %b want 0", ws_fwd_valid); else n_pass++;
    n_checks++; if (debug_wb_pc !== 32'h0) $display("FAIL arst_debug_pc: got %h want 0", debug_wb_pc); else n_pass++;
    n_checks++; if (retire_cnt !== 32'h0) $display("FAIL arst_cnt: got %h want 0", retire_cnt); else n_pass++;
    n_checks++; if (rf_waddr !== 5'd0) $display("FAIL arst_waddr: got %0d want 0", rf_waddr); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    pend = 1'b0; exp_cnt = 32'd0;
    idle();
    n_checks++; if (retire_cnt !== 32'h0) $display("FAIL arst_discard_cnt: got %h want 0", retire_cnt); else n_pass++;
    issue(32'h0000_0500, 2'b00, 4'hF, 5'd6, 32'h6666_6666, LD_LW, 2'd0);
    idle();
    n_checks++; if (retire_cnt !== 32'h1) $display("FAIL post_rst_cnt: got %h want 1", retire_cnt); else n_pass++;
    n_checks++; if (retire_cnt !== exp_cnt) $display("FAIL model_cnt: got %h want %h", retire_cnt, exp_cnt); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lb();
    test_load_ext();
    test_link();
    test_alu();
    test_flush_accept();
    test_flush_held();
    test_dest0();
    test_back_to_back();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 ms_to_ws_valid  in  1  MEM stage presents a valid instruction this cycle.
REQ-004 ws_allowin  out  1  WB accepts a new instruction; held constant 1 (WB never stalls).
REQ-005 ms_pc  in  32  PC of the incoming instruction.
REQ-006 ms_sel_wbdata  in  2  write-back source: 00 ALU, 01 load, 10 link (pc+8), 11 ALU.
REQ-007 ms_reg_we  in  4  per-byte register-file write enable.
REQ-008 ms_dest  in  5  destination register number.
REQ-009 ms_aluout  in  32  ALU result.
REQ-010 ms_ld_op  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others are treated as lw.
REQ-011 ms_addr_low  in  2  data address bits [1:0].
REQ-012 data_sram_rdata  in  32  synchronous SRAM read data, valid in the cycle the load is held in WB.
REQ-013 flush  in  1  exception flush; kills the instruction held in WB.
REQ-014 rf_we  out  4  register-file byte write enable.
REQ-015 rf_waddr  out  5  register-file write address.
REQ-016 rf_wdata  out  32  register-file write data.
REQ-017 ws_fwd_valid  out  1  forwarding/bypass of WB result is valid.
REQ-018 ws_fwd_dest  out  5  forwarding destination, equal to rf_waddr.
REQ-019 debug_wb_pc  out  32  PC of the instruction in WB.
REQ-020 retire_cnt  out  32  count of retired instructions.

Function
REQ-021 ws_valid register SHALL load ms_to_ws_valid on every edge, since ws_allowin is 1.
REQ-022 Payload registers SHALL capture pc, sel_wbdata, reg_we, dest, aluout, ld_op and addr_low only when ms_to_ws_valid=1; otherwise they hold their value.
REQ-023 WB latency SHALL be one cycle: an instruction accepted at edge N is written to the register file during cycle N..N+1.
REQ-024 Load extraction SHALL be combinational on data_sram_rdata: byte = rdata[8*addr_low+7 : 8*addr_low]; half = rdata[31:16] if addr_low[1] else rdata[15:0].
REQ-025 lb/lh SHALL sign-extend to 32 bits and lbu/lhu SHALL zero-extend; lw SHALL pass rdata unchanged.
REQ-026 A misaligned half access (addr_low[0]=1) SHALL use addr_low[1] only; alignment exceptions are raised upstream.
REQ-027 Link data SHALL be ws_pc+8, computed modulo 2^32.
REQ-028 rf_we SHALL equal ws_reg_we when ws_valid=1 and flush=0, and 4'b0000 otherwise.
REQ-029 A write to dest 0 SHALL drive rf_we=0 and ws_fwd_valid=0.
REQ-030 ws_fwd_valid SHALL equal (rf_we!=0); ws_fwd_dest SHALL equal ws_dest.
REQ-031 flush=1 SHALL clear ws_valid at the next edge, suppress writes in the current cycle, and block counting.
REQ-032 If flush and ms_to_ws_valid are both 1 in the same cycle, flush SHALL win: ws_valid becomes 0.
REQ-033 retire_cnt SHALL increment by 1 on each edge where ws_valid=1 and flush=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 debug_wb_pc SHALL equal ws_pc regardless of ws_valid.

Reset
REQ-035 While resetn=0, ws_valid, all payload registers and retire_cnt SHALL be 0 immediately; rf_we, ws_fwd_valid and debug_wb_pc are therefore 0.
REQ-036 Reset deasserted mid-stream SHALL discard the in-flight instruction with no register-file write.

Structure
REQ-037 The ld_op and sel_wbdata encodings SHALL be defined as constants in the shared CPU package.
REQ-038 Load alignment/extension SHALL be a combinational sub-module named load_align.

Verification
REQ-039 lb: addr_low=2, rdata=0x12F45678 -> rf_wdata=0xFFFFFFF4, rf_we=1111 one cycle after acceptance.
REQ-040 lhu: addr_low=2, rdata=0x8001ABCD -> rf_wdata=0x00008001.
REQ-041 Link: sel=10, pc=0xBFC00100, dest=31 -> rf_wdata=0xBFC00108, rf_waddr=31.
REQ-042 flush and ms_to_ws_valid high together -> no rf_we in this cycle or the next; retire_cnt unchanged.
REQ-043 dest=0 with reg_we=1111 -> rf_we=0000 and ws_fwd_valid=0; retire_cnt still increments.
REQ-044 Preload retire_cnt=0xFFFFFFFF via a forced register, retire one instruction -> retire_cnt=0; assert resetn=0 asynchronously -> all outputs 0 before the next edge.
